// File: rtl/rr_mux_arbiter.sv
// Four-input round-robin arbiter with a registered select and a hold limit per ownership.
// The granted source's data word is muxed onto y; y reads zero whenever nothing is granted.
module rr_mux_arbiter #(
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [3:0]   gnt,
  output logic         s1,
  output logic         s2,
  output logic [W-1:0] y,
  output logic         y_vld
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [1:0] r_sel, w_sel_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic [3:0] r_hold_cnt, w_hold_nxt;
  logic [1:0] w_base;
  logic [1:0] w_pick;
  logic       w_found;
  logic       w_release;

  // r_sel is the current owner while BUSY and the last owner while IDLE.
  assign w_release = (r_state == BUSY) && (!req[r_sel] || (r_hold_cnt == HOLD_LAST));
  assign w_base    = (r_state == BUSY) ? r_sel + 2'd1 : r_ptr;

  // Scan from the farthest offset down so the nearest requester to w_base wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = w_base;
    for (int i = 3; i >= 0; i--) begin
      if (req[w_base + 2'(i)]) begin
        w_found = 1'b1;
        w_pick  = w_base + 2'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_gnt_nxt   = r_gnt;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = BUSY;
          w_gnt_nxt   = 4'b0001 << w_pick;
          w_sel_nxt   = w_pick;
          w_hold_nxt  = 4'd0;
        end
      end
      BUSY: begin
        if (!w_release) begin
          w_hold_nxt = r_hold_cnt + 4'd1;
        end else begin
          w_ptr_nxt  = r_sel + 2'd1;
          w_hold_nxt = 4'd0;
          if (w_found) begin
            w_gnt_nxt = 4'b0001 << w_pick;
            w_sel_nxt = w_pick;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = 4'b0000;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= 2'd0;
      r_sel      <= 2'd0;
      r_gnt      <= 4'b0000;
      r_hold_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_sel      <= w_sel_nxt;
      r_gnt      <= w_gnt_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  assign gnt   = r_gnt;
  assign s1    = r_sel[1];
  assign s2    = r_sel[0];
  assign y_vld = |r_gnt;

  always_comb begin
    y = '0;
    if (y_vld) begin
      case (r_sel)
        2'd0:    y = a;
        2'd1:    y = b;
        2'd2:    y = c;
        default: y = d;
      endcase
    end
  end

endmodule
